// File: rtl/vga_timing_gen_if.sv
//------------------------------------------------------------------------------
// vga_timing_gen_if
//
// Purpose:
//   Pixel-request bus between the VGA timing generator and the pixel source
//   (ALU / framebuffer). The generator announces which pixel it wants. The
//   source answers with that pixel's colour within the same pixel slot.
//
// Parameters:
//   RGB_SIZE  bits per colour channel
//   CNT_W     coordinate width
//
// Signals:
//   o_request      generator -> source  current slot is an active pixel
//   o_x, o_y       generator -> source  requested column / row (0 when idle)
//   o_pix_en       generator -> source  one-clk pixel-slot strobe
//   o_frame_start  generator -> source  one-clk pulse at frame wrap
//   i_red/green/blue  source -> generator  colour for (o_x, o_y)
//
// Modports:
//   master  the timing generator
//   slave   the pixel source
//------------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int RGB_SIZE = 8,
  parameter int CNT_W    = 11
);

  logic                o_request;
  logic [CNT_W-1:0]    o_x;
  logic [CNT_W-1:0]    o_y;
  logic                o_pix_en;
  logic                o_frame_start;
  logic [RGB_SIZE-1:0] i_red;
  logic [RGB_SIZE-1:0] i_green;
  logic [RGB_SIZE-1:0] i_blue;

  modport master (
    output o_request,
    output o_x,
    output o_y,
    output o_pix_en,
    output o_frame_start,
    input  i_red,
    input  i_green,
    input  i_blue
  );

  modport slave (
    input  o_request,
    input  o_x,
    input  o_y,
    input  o_pix_en,
    input  o_frame_start,
    output i_red,
    output i_green,
    output i_blue
  );

endinterface

// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Parametrised VGA timing and pixel-pipeline generator. A prescaler divides
//   clk into pixel slots. Horizontal and vertical counters walk the raster.
//   The current position is offered to the pixel source as a coordinate
//   request. The returned colour is registered together with sync and blank,
//   so every DAC pin shows slot N's values during slot N+1.
//
// Optional feature (macro VGA_TEST_PATTERN_EN):
//   When the macro is defined and pattern_sel = 1, the colour from the pixel
//   source is replaced by 8 full-scale vertical colour bars. Bar index is
//   o_x*8/H_ACTIVE, with bit2 = R, bit1 = G and bit0 = B.
//   When the macro is undefined, pattern_sel is ignored and no pattern logic
//   is built.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   pattern_sel  selects the internal test pattern (only with the macro)
//   bus          pixel-request interface (master side)
//   o_vga_r/g/b  colour to DAC, zero outside visible pixels
//   o_hsync      horizontal sync, active level HS_POL
//   o_vsync      vertical sync, active level VS_POL
//   o_sync       composite sync, tied to 0
//   o_blank      active-low blank, 1 only during visible pixels
//------------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int RGB_SIZE = 8,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pattern_sel,
  vga_timing_gen_if.master    bus,
  output logic [RGB_SIZE-1:0] o_vga_r,
  output logic [RGB_SIZE-1:0] o_vga_g,
  output logic [RGB_SIZE-1:0] o_vga_b,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_sync,
  output logic                o_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A one-bit prescaler is kept even for CLK_DIV = 1. It then never leaves 0,
  // so the slot strobe is permanently high.
  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT_LVL = (HS_POL != 0);
  localparam logic VS_ACT_LVL = (VS_POL != 0);

  logic [PRESC_W-1:0]  r_presc;
  logic [CNT_W-1:0]    r_hCnt;
  logic [CNT_W-1:0]    r_vCnt;
  logic [RGB_SIZE-1:0] r_vgaR;
  logic [RGB_SIZE-1:0] r_vgaG;
  logic [RGB_SIZE-1:0] r_vgaB;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_blank;

  logic                w_pixEn;
  logic                w_hLast;
  logic                w_vLast;
  logic                w_request;
  logic                w_inHsync;
  logic                w_inVsync;
  logic [CNT_W-1:0]    w_x;
  logic [CNT_W-1:0]    w_y;
  logic [RGB_SIZE-1:0] w_red;
  logic [RGB_SIZE-1:0] w_green;
  logic [RGB_SIZE-1:0] w_blue;

  // Raster decode from the counters.
  assign w_pixEn   = (r_presc == PRESC_LAST);
  assign w_hLast   = (r_hCnt == H_LAST);
  assign w_vLast   = (r_vCnt == V_LAST);
  assign w_request = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
  assign w_inHsync = (r_hCnt >= HS_START) && (r_hCnt < HS_END);
  assign w_inVsync = (r_vCnt >= VS_START) && (r_vCnt < VS_END);
  assign w_x       = w_request ? r_hCnt : '0;
  assign w_y       = w_request ? r_vCnt : '0;

  // The frame strobe is decoded directly from the counters. It is qualified
  // with reset, so the strobe stays low for the whole time reset is held.
  assign bus.o_request     = w_request;
  assign bus.o_x           = w_x;
  assign bus.o_y           = w_y;
  assign bus.o_pix_en      = w_pixEn;
  assign bus.o_frame_start = w_pixEn & w_hLast & w_vLast & reset;

`ifdef VGA_TEST_PATTERN_EN
  // Colour bars. The divisor is a constant, so this reduces to fixed
  // thresholds on the column. Outside request slots w_x is 0, but the
  // output stage blanks those slots anyway.
  localparam logic [CNT_W+2:0] BAR_DIV = (CNT_W+3)'(H_ACTIVE);
  logic [2:0] w_barIdx;
  assign w_barIdx = 3'({w_x, 3'b000} / BAR_DIV);
  assign w_red    = pattern_sel ? {RGB_SIZE{w_barIdx[2]}} : bus.i_red;
  assign w_green  = pattern_sel ? {RGB_SIZE{w_barIdx[1]}} : bus.i_green;
  assign w_blue   = pattern_sel ? {RGB_SIZE{w_barIdx[0]}} : bus.i_blue;
`else
  logic w_unusedPatternSel;
  assign w_unusedPatternSel = pattern_sel;
  assign w_red   = bus.i_red;
  assign w_green = bus.i_green;
  assign w_blue  = bus.i_blue;
`endif

  // Pixel-slot prescaler: counts 0..CLK_DIV-1 and restarts on the strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_pixEn) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Raster counters advance once per pixel slot. The line counter steps
  // only when the column counter wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_pixEn) begin
      if (w_hLast) begin
        r_hCnt <= '0;
        r_vCnt <= w_vLast ? '0 : r_vCnt + CNT_W'(1);
      end else begin
        r_hCnt <= r_hCnt + CNT_W'(1);
      end
    end
  end

  // Output stage: captures the slot's colour, blank and sync at the end of
  // the slot. All pins are registered here, so they change on the same
  // edge and show the previous slot for exactly one slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vgaR  <= '0;
      r_vgaG  <= '0;
      r_vgaB  <= '0;
      r_blank <= 1'b0;
      r_hsync <= ~HS_ACT_LVL;
      r_vsync <= ~VS_ACT_LVL;
    end else if (w_pixEn) begin
      r_vgaR  <= w_request ? w_red   : '0;
      r_vgaG  <= w_request ? w_green : '0;
      r_vgaB  <= w_request ? w_blue  : '0;
      r_blank <= w_request;
      r_hsync <= w_inHsync ? HS_ACT_LVL : ~HS_ACT_LVL;
      r_vsync <= w_inVsync ? VS_ACT_LVL : ~VS_ACT_LVL;
    end
  end

  assign o_vga_r = r_vgaR;
  assign o_vga_g = r_vgaG;
  assign o_vga_b = r_vgaB;
  assign o_blank = r_blank;
  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
  assign o_sync  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
//------------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two generators with a shrunken raster run side by side. Both use a 25-pixel
// line and an 11-line frame. Instance 0 uses CLK_DIV = 2 with active-low
// syncs. Instance 1 uses CLK_DIV = 1 with active-high syncs.
//
// The reference position is derived from the number of clocks since reset
// release. Pin values expected for a slot are queued when that slot's colour
// is driven. The queued entry is popped when the next slot begins and is
// held as the expectation for that whole slot.
//
// Honours VGA_TEST_PATTERN_EN for the colour-bar expectation.
//------------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 4;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NCYC  = 1500;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_ON = 1'b1;
`else
  localparam bit PAT_ON = 1'b0;
`endif

  typedef struct packed {
    logic        blank;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
  } pins_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic patternSel = 1'b0;

  logic [7:0] vgaR0, vgaG0, vgaB0, vgaR1, vgaG1, vgaB1;
  logic       hs0, vs0, sync0, blank0, hs1, vs1, sync1, blank1;

  int    vecCount = 0;
  int    errCount = 0;
  int    n[2] = '{0, 0};
  pins_t cur[2];
  pins_t sbQ0[$];
  pins_t sbQ1[$];

  vga_timing_gen_if #(.RGB_SIZE(8), .CNT_W(11)) bus0 ();
  vga_timing_gen_if #(.RGB_SIZE(8), .CNT_W(11)) bus1 ();

  vga_timing_gen #(
    .RGB_SIZE(8), .CLK_DIV(2),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .CNT_W(11)
  ) dut0 (
    .clk(clk), .reset(reset), .pattern_sel(patternSel), .bus(bus0.master),
    .o_vga_r(vgaR0), .o_vga_g(vgaG0), .o_vga_b(vgaB0),
    .o_hsync(hs0), .o_vsync(vs0), .o_sync(sync0), .o_blank(blank0)
  );

  vga_timing_gen #(
    .RGB_SIZE(8), .CLK_DIV(1),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1), .VS_POL(1), .CNT_W(11)
  ) dut1 (
    .clk(clk), .reset(reset), .pattern_sel(patternSel), .bus(bus1.master),
    .o_vga_r(vgaR1), .o_vga_g(vgaG1), .o_vga_b(vgaB1),
    .o_hsync(hs1), .o_vsync(vs1), .o_sync(sync1), .o_blank(blank1)
  );

  always #5 clk = ~clk;

  // Clocks since reset release, per instance.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      n[d] <= reset ? n[d] + 1 : 0;
    end
  end

  function automatic int divOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic polOf(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic pins_t resetPins(input int d);
    pins_t p;
    p.blank = 1'b0;
    p.rgb   = 24'h0;
    p.hs    = ~polOf(d);
    p.vs    = ~polOf(d);
    return p;
  endfunction

  function automatic pins_t slotPins(input int d, input int h, input int v,
                                     input logic [7:0] r, input logic [7:0] g,
                                     input logic [7:0] b, input logic psel);
    pins_t      p;
    logic       req;
    logic [7:0] cr, cg, cb;
    int         bar;
    req = (h < HA) && (v < VA);
    cr = r;
    cg = g;
    cb = b;
    if (PAT_ON && psel) begin
      bar = (h * 8) / HA;
      cr = bar[2] ? 8'hFF : 8'h00;
      cg = bar[1] ? 8'hFF : 8'h00;
      cb = bar[0] ? 8'hFF : 8'h00;
    end
    p.blank = req;
    p.rgb   = req ? {cr, cg, cb} : 24'h0;
    p.hs    = (h >= HA + HFP && h < HA + HFP + HSW) ? polOf(d) : ~polOf(d);
    p.vs    = (v >= VA + VFP && v < VA + VFP + VSW) ? polOf(d) : ~polOf(d);
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    vecCount++;
    if (obs !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Checks one instance at the current negedge, then picks its next colour
  // inputs and queues the pin values those inputs should produce.
  task automatic applyStimulus(input int d, input logic rstNow, input logic pselNext,
                               input logic reqO, input logic [10:0] xO,
                               input logic [10:0] yO, input logic pixO, input logic fsO,
                               input logic blankO, input logic [7:0] rO,
                               input logic [7:0] gO, input logic [7:0] bO,
                               input logic hsO, input logic vsO, input logic syncO,
                               output logic [7:0] nr, output logic [7:0] ng,
                               output logic [7:0] nb);
    int    div, s, ph, idx, h, v;
    logic  req;
    pins_t p;
    string pre;
    div = divOf(d);
    s   = n[d] / div;
    ph  = n[d] % div;
    idx = s % FRAME;
    h   = idx % HT;
    v   = idx / HT;
    req = (h < HA) && (v < VA);
    pre = $sformatf("d%0d.", d);

    if (n[d] == 0) begin
      if (d == 0) sbQ0.delete(); else sbQ1.delete();
      cur[d] = resetPins(d);
    end else if (ph == 0) begin
      if (d == 0 && sbQ0.size() > 0) cur[d] = sbQ0.pop_front();
      if (d == 1 && sbQ1.size() > 0) cur[d] = sbQ1.pop_front();
    end

    checkOutput({pre, "request"},    32'(reqO),   32'(req));
    checkOutput({pre, "x"},          32'(xO),     req ? h : 0);
    checkOutput({pre, "y"},          32'(yO),     req ? v : 0);
    checkOutput({pre, "pixEn"},      32'(pixO),   32'(ph == div - 1));
    checkOutput({pre, "frameStart"}, 32'(fsO),
                32'(rstNow && ph == div - 1 && idx == FRAME - 1));
    checkOutput({pre, "blank"},      32'(blankO), 32'(cur[d].blank));
    checkOutput({pre, "rgb"},        {8'h0, rO, gO, bO}, {8'h0, cur[d].rgb});
    checkOutput({pre, "hsync"},      32'(hsO),    32'(cur[d].hs));
    checkOutput({pre, "vsync"},      32'(vsO),    32'(cur[d].vs));
    checkOutput({pre, "sync"},       32'(syncO),  32'h0);

    // Red follows the requested column. Green and blue are random and change
    // every clock, so only the value held at the end of the slot counts.
    nr = xO[7:0];
    ng = 8'($urandom);
    nb = 8'($urandom);
    if (ph == div - 1) begin
      p = slotPins(d, h, v, nr, ng, nb, pselNext);
      if (d == 0) sbQ0.push_back(p); else sbQ1.push_back(p);
    end
  endtask

  initial begin
    logic       rstNext, pselNext;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    bus0.i_red = '0; bus0.i_green = '0; bus0.i_blue = '0;
    bus1.i_red = '0; bus1.i_green = '0; bus1.i_blue = '0;
    $display("[TB] starting, pattern build = %0d", PAT_ON);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      // Reset at start and again mid-frame, mid-line; bars in the last part.
      rstNext  = !((c < 5) || (c >= 803 && c < 806));
      pselNext = (c >= 1100);
      applyStimulus(0, reset, pselNext, bus0.o_request, bus0.o_x, bus0.o_y,
                    bus0.o_pix_en, bus0.o_frame_start, blank0, vgaR0, vgaG0, vgaB0,
                    hs0, vs0, sync0, r0, g0, b0);
      applyStimulus(1, reset, pselNext, bus1.o_request, bus1.o_x, bus1.o_y,
                    bus1.o_pix_en, bus1.o_frame_start, blank1, vgaR1, vgaG1, vgaB1,
                    hs1, vs1, sync1, r1, g1, b1);
      reset      = rstNext;
      patternSel = pselNext;
      bus0.i_red = r0; bus0.i_green = g0; bus0.i_blue = b0;
      bus1.i_red = r1; bus1.i_green = g1; bus1.i_blue = b1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
